stream_mux_rr: RTL and testbench

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes, a registered output stage and two modes: fixed-select, or round-robin arbitration. Packets are locked to one channel until the beat marked last. It succeeds the fixed 2/4/8-input combinational muxes in the datapath library. It sits wherever several producer streams share one consumer and the sharing needs backpressure, fairness or packet integrity.

---
 rtl/stream_mux_rr.sv | 172 +++++++++++++++++
 tb/tb_stream_mux_rr.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Fixed-select or round-robin arbitration; a packet holds its grant until its last beat.
module stream_mux_rr #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NCH   = 8,
  parameter int unsigned SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH-1:0]       in_last,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e           state_q, state_d;
  logic [SELW-1:0]  gnt_q, gnt_d;
  logic             gnt_rr_q, gnt_rr_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;

  logic             load;
  logic             xfer;
  logic [SELW-1:0]  cand;
  logic             cand_hit;
  logic             pick_valid;
  logic             pick_last;
  logic [WIDTH-1:0] pick_data;
  logic [NCH-1:0]   rot_valid;

  function automatic logic [SELW-1:0] next_ch(input logic [SELW-1:0] c);
    if (int'(c) + 1 >= int'(NCH)) begin
      next_ch = '0;
    end else begin
      next_ch = c + 1'b1;
    end
  endfunction

  assign load = !valid_q || out_ready;

  // in_valid rotated so that bit k is channel (ptr + k) mod NCH.
  assign rot_valid = NCH'({in_valid, in_valid} >> ptr_q);

  always_comb begin
    cand     = '0;
    cand_hit = 1'b0;
    if (state_q == StLocked) begin
      cand     = gnt_q;
      cand_hit = 1'b1;
    end else if (!mode) begin
      if (int'(sel) < int'(NCH)) begin
        cand     = sel;
        cand_hit = 1'b1;
      end
    end else begin
      for (int k = 0; k < int'(NCH); k++) begin
        if (!cand_hit && rot_valid[k]) begin
          cand     = SELW'((int'(ptr_q) + k) % int'(NCH));
          cand_hit = 1'b1;
        end
      end
    end
  end

  // Constant-index mux keeps every select in range for any NCH/SELW pairing.
  always_comb begin
    pick_valid = 1'b0;
    pick_last  = 1'b0;
    pick_data  = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (cand == SELW'(i)) begin
        pick_valid = in_valid[i];
        pick_last  = in_last[i];
        pick_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = cand_hit && pick_valid && load && !rst;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (xfer && cand == SELW'(i)) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_rr_d = gnt_rr_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    ch_d     = ch_q;

    if (load) begin
      valid_d = xfer;
    end

    if (xfer) begin
      data_d = pick_data;
      last_d = pick_last;
      ch_d   = cand;
      unique case (state_q)
        StIdle: begin
          if (!pick_last) begin
            state_d  = StLocked;
            gnt_d    = cand;
            gnt_rr_d = mode;
          end else if (mode) begin
            ptr_d = next_ch(cand);
          end
        end
        StLocked: begin
          // Pointer only moves for packets that were won by round-robin.
          if (pick_last) begin
            state_d = StIdle;
            if (gnt_rr_q) begin
              ptr_d = next_ch(gnt_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_rr_q <= 1'b0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      ch_q     <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_rr_q <= gnt_rr_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      ch_q     <= ch_d;
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_ch    = ch_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a cycle model predicts grants and in_ready,
// accepted beats are queued and compared in order as the output drains.
module tb_stream_mux_rr;

  localparam int WIDTH = 4;
  localparam int NCH   = 8;
  localparam int SELW  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_last;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  always #5 clk = ~clk;

  stream_mux_rr #(
    .WIDTH(WIDTH),
    .NCH  (NCH),
    .SELW (SELW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_ch   (out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [SELW-1:0]  ch;
  } beat_t;

  beat_t sb[$];
  int    obs[$];
  int    checks = 0;
  int    errors = 0;

  logic  m_locked;
  logic  m_rr;
  logic  m_ov;
  int    m_gnt;
  int    m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_rr     = 1'b0;
    m_ov     = 1'b0;
    m_gnt    = 0;
    m_ptr    = 0;
    sb.delete();
    obs.delete();
  endtask

  task automatic set_data_idx();
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'(i);
  endtask

  task automatic set_data_rand();
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int             c;
    logic           ok;
    logic           ld;
    logic [NCH-1:0] er;
    beat_t          b;
    #3;
    c  = 0;
    ok = 1'b0;
    if (m_locked) begin
      c  = m_gnt;
      ok = in_valid[c];
    end else if (!mode) begin
      if (int'(sel) < NCH) begin
        c  = int'(sel);
        ok = in_valid[c];
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!ok && in_valid[(m_ptr + k) % NCH]) begin
          c  = (m_ptr + k) % NCH;
          ok = 1'b1;
        end
      end
    end
    ld = !m_ov || out_ready;
    er = '0;
    if (ld && ok) er[c] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(er));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        b = sb[0];
        check("out_data", 32'(out_data), 32'(b.data));
        check("out_last", 32'(out_last), 32'(b.last));
        check("out_ch", 32'(out_ch), 32'(b.ch));
        if (out_ready) begin
          void'(sb.pop_front());
          obs.push_back(int'(out_ch));
        end
      end
    end
    if (ld) begin
      if (ok) begin
        b.data = in_data[c*WIDTH +: WIDTH];
        b.last = in_last[c];
        b.ch   = c[SELW-1:0];
        sb.push_back(b);
        if (!m_locked) begin
          if (!in_last[c]) begin
            m_locked = 1'b1;
            m_gnt    = c;
            m_rr     = mode;
          end else if (mode) begin
            m_ptr = (c + 1) % NCH;
          end
        end else if (in_last[c]) begin
          m_locked = 1'b0;
          if (m_rr) m_ptr = (m_gnt + 1) % NCH;
        end
      end
      m_ov = ok;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_last = '0; in_data = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // Traffic, then an asynchronous reset in the middle of a cycle.
    mode = 1'b1; in_valid = '1; in_last = '1; set_data_idx();
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Round-robin fairness from reset: 0..7 then wrap to 0, back to back.
    repeat (10) step();
    check("rr_cnt", 32'(obs.size()), 32'd9);
    for (int i = 0; i < obs.size() && i < 9; i++) check("rr_seq", 32'(obs[i]), 32'(i % NCH));
    drain();

    // Fixed select of channel 5, then an out-of-range select.
    obs.delete();
    mode = 1'b0; sel = 4'd5; in_valid = '1; in_last = '1; set_data_idx();
    repeat (5) step();
    #1 check("fix_ready", 32'(in_ready), 32'h20);
    sel = 4'd9;
    repeat (2) step();
    check("oor_out_valid", 32'(out_valid), 32'd0);
    check("fix_cnt", 32'(obs.size()), 32'd5);
    for (int i = 0; i < obs.size(); i++) check("fix_seq", 32'(obs[i]), 32'd5);
    drain();

    // Three-beat packet on ch2 with a two-cycle gap; ch3 waits.
    obs.delete();
    mode = 1'b1; in_last = '0; set_data_rand();
    in_valid = 8'b0000_0100; step();
    in_valid = 8'b0000_1100; in_last = 8'b0000_1000; set_data_rand(); step();
    in_valid = 8'b0000_1000;
    #1 check("gap_ready", 32'(in_ready), 32'd0);
    step(); step();
    in_valid = 8'b0000_1100; in_last = 8'b0000_1100; set_data_rand(); step();
    in_valid = 8'b0000_1000; set_data_rand(); step();
    drain();
    check("lock_cnt", 32'(obs.size()), 32'd4);
    for (int i = 0; i < obs.size() && i < 4; i++)
      check("lock_seq", 32'(obs[i]), (i < 3) ? 32'd2 : 32'd3);

    // Backpressure: output frozen for four cycles, no loss or duplication.
    obs.delete();
    mode = 1'b1; in_valid = '1; in_last = '1;
    for (int i = 0; i < 4; i++) begin set_data_rand(); step(); end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin set_data_rand(); step(); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin set_data_rand(); step(); end
    drain();
    check("bp_cnt", 32'(obs.size()), 32'd8);

    // Mode switch while locked on ch1: packet completes, then fixed grant to ch6.
    obs.delete();
    mode = 1'b1; in_valid = 8'b0000_0010; in_last = '0; set_data_rand(); step();
    mode = 1'b0; sel = 4'd6; in_valid = 8'b0100_0010; set_data_rand(); step();
    in_last = 8'b0100_0010; set_data_rand(); step();
    in_valid = 8'b0100_0000; set_data_rand(); step();
    drain();
    check("sw_cnt", 32'(obs.size()), 32'd4);
    for (int i = 0; i < obs.size() && i < 4; i++)
      check("sw_seq", 32'(obs[i]), (i < 3) ? 32'd1 : 32'd6);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
